// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit words LSB first through one full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output Ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_c;

  // The single full-adder cell being time-shared across all bit positions.
  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) |
                (a_q[0] & carry_q) |
                (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_s;
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        carry_d        = fa_c;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          s_d     = sum_d;
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q still holds the carry into the MSB here
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule
